// File: rtl/hs_dpath_pkg.sv
// Shared helpers for the handshake datapath blocks.
package hs_dpath_pkg;

    // Width needed to hold a count in the range 0..n.
    function automatic int hs_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/hs_dpath_sipo_vr.sv
// Serial-in/parallel-out deserializer with valid/ready on both sides.
// Beats fill a collect buffer; closing beat transfers the merged word to the output register.
module hs_dpath_sipo_vr
    import hs_dpath_pkg::*;
#(
    parameter type      DATA_TYPE   = logic,
    parameter DATA_TYPE RESET_VALUE = '0,
    parameter int       RATIO       = 4
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic                         sclr,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  DATA_TYPE                     s_data,
    input  logic                         s_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output DATA_TYPE                     m_data [RATIO],
    output logic [hs_cnt_w(RATIO)-1:0]   m_count
);

    localparam int CW = $clog2(RATIO);
    localparam int MW = hs_cnt_w(RATIO);

    logic [CW-1:0] r_cnt;
    logic          r_mvalid;
    logic [MW-1:0] r_mcount;
    DATA_TYPE      r_mdata  [RATIO];
    DATA_TYPE      w_merged [RATIO];

    logic w_close_possible;
    logic w_s_ready;
    logic w_accept;
    logic w_close;

    assign w_close_possible = (r_cnt == CW'(RATIO - 1)) || s_last;
    // Only a closing beat needs room in the output register.
    assign w_s_ready        = !w_close_possible || !r_mvalid || m_ready;
    assign w_accept         = s_valid && w_s_ready;
    assign w_close          = w_accept && w_close_possible;

    for (genvar g = 0; g < RATIO; g++) begin : g_cbuf
        DATA_TYPE r_elem;
        logic     w_en;

        assign w_en = w_accept && (r_cnt == CW'(g));

        always_ff @(posedge clk or negedge aresetn) begin
            if (!aresetn) begin
                r_elem <= RESET_VALUE;
            end else if (sclr || w_close) begin
                r_elem <= RESET_VALUE;
            end else if (w_en) begin
                r_elem <= s_data;
            end
        end

        // Elements beyond cnt are already RESET_VALUE, so only the live slot needs merging.
        assign w_merged[g] = w_en ? s_data : r_elem;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt <= '0;
        end else if (sclr || w_close) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_mvalid <= 1'b0;
            r_mcount <= '0;
            for (int i = 0; i < RATIO; i++) r_mdata[i] <= RESET_VALUE;
        end else if (sclr) begin
            r_mvalid <= 1'b0;
            r_mcount <= '0;
            for (int i = 0; i < RATIO; i++) r_mdata[i] <= RESET_VALUE;
        end else if (w_close) begin
            r_mvalid <= 1'b1;
            r_mcount <= MW'(r_cnt) + MW'(1);
            r_mdata  <= w_merged;
        end else if (r_mvalid && m_ready) begin
            r_mvalid <= 1'b0;
        end
    end

    assign s_ready = w_s_ready;
    assign m_valid = r_mvalid;
    assign m_data  = r_mdata;
    assign m_count = r_mcount;

`ifndef SYNTHESIS
    if (RATIO < 2 || RATIO > 65535) begin : g_bad_ratio
        $error("hs_dpath_sipo_vr: RATIO must be in 2..65535");
    end

    a_count_nonzero: assert property (@(posedge clk) disable iff (!aresetn)
        r_mvalid |-> (r_mcount != '0));

    a_count_stable: assert property (@(posedge clk) disable iff (!aresetn)
        (r_mvalid && !m_ready && !sclr) |=> $stable(r_mcount));

    for (genvar g = 0; g < RATIO; g++) begin : g_stable
        a_data_stable: assert property (@(posedge clk) disable iff (!aresetn)
            (r_mvalid && !m_ready && !sclr) |=> $stable(r_mdata[g]));
    end
`endif

endmodule

// File: tb/tb_hs_dpath_sipo_vr.sv
// Directed bench for hs_dpath_sipo_vr with RATIO=4 and 8-bit beats.
module tb_hs_dpath_sipo_vr;

    logic       clk = 1'b0;
    logic       aresetn;
    logic       sclr;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data [4];
    logic [2:0] m_count;

    int n_checks = 0;
    int n_errors = 0;

    hs_dpath_sipo_vr #(
        .DATA_TYPE   (logic [7:0]),
        .RESET_VALUE (8'h00),
        .RATIO       (4)
    ) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .sclr    (sclr),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_count (m_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, input logic [2:0] cnt);
        chk({tag, ".m_valid"}, 32'(m_valid), 32'd1);
        chk({tag, ".d0"}, 32'(m_data[0]), 32'(e0));
        chk({tag, ".d1"}, 32'(m_data[1]), 32'(e1));
        chk({tag, ".d2"}, 32'(m_data[2]), 32'(e2));
        chk({tag, ".d3"}, 32'(m_data[3]), 32'(e3));
        chk({tag, ".count"}, 32'(m_count), 32'(cnt));
    endtask

    // One accepted beat; caller guarantees s_ready.
    task automatic beat(input logic [7:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0;
        sclr    = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        m_ready = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        tick();

        // 1: reset state, then async reset mid-word
        chk("rst.m_valid", 32'(m_valid), 32'd0);
        chk("rst.m_count", 32'(m_count), 32'd0);
        chk("rst.d0", 32'(m_data[0]), 32'd0);
        chk("rst.s_ready", 32'(s_ready), 32'd1);
        m_ready = 1'b1;
        beat(8'hE1, 1'b0);
        beat(8'hE2, 1'b0);
        #2 aresetn = 1'b0;
        #1;
        chk("arst.m_valid", 32'(m_valid), 32'd0);
        chk("arst.m_count", 32'(m_count), 32'd0);
        chk("arst.d3", 32'(m_data[3]), 32'd0);
        chk("arst.s_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        aresetn = 1'b1;

        // 2: full word after reset, latency one edge after 4th accept
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b0);
        chk("w1.early_valid", 32'(m_valid), 32'd0);
        beat(8'h44, 1'b0);
        chk_word("w1", 8'h11, 8'h22, 8'h33, 8'h44, 3'd4);
        tick();
        chk("w1.drained", 32'(m_valid), 32'd0);

        // 3: 12 back-to-back beats -> 3 words, no stall
        for (int i = 0; i < 12; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h30 + i);
            s_last  = 1'b0;
            #1;
            chk("b2b.s_ready", 32'(s_ready), 32'd1);
            tick();
            if (i % 4 == 3)
                chk_word("b2b", 8'(8'h30 + i - 3), 8'(8'h30 + i - 2),
                         8'(8'h30 + i - 1), 8'(8'h30 + i), 3'd4);
            else
                chk("b2b.m_valid", 32'(m_valid), 32'd0);
        end
        s_valid = 1'b0;
        tick();
        chk("b2b.drained", 32'(m_valid), 32'd0);

        // 4: backpressure, beats 5-7 accepted, beat 8 stalls, zero-bubble handover
        m_ready = 1'b0;
        beat(8'h51, 1'b0);
        beat(8'h52, 1'b0);
        beat(8'h53, 1'b0);
        beat(8'h54, 1'b0);
        chk_word("bp.w1", 8'h51, 8'h52, 8'h53, 8'h54, 3'd4);
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h55 + i);
            #1;
            chk("bp.nonclose_ready", 32'(s_ready), 32'd1);
            tick();
            chk_word("bp.hold", 8'h51, 8'h52, 8'h53, 8'h54, 3'd4);
        end
        s_valid = 1'b1;
        s_data  = 8'h58;
        #1;
        chk("bp.stall", 32'(s_ready), 32'd0);
        tick();
        chk("bp.stall2", 32'(s_ready), 32'd0);
        chk_word("bp.hold2", 8'h51, 8'h52, 8'h53, 8'h54, 3'd4);
        m_ready = 1'b1;
        #1;
        chk("bp.release", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        chk_word("bp.w2", 8'h55, 8'h56, 8'h57, 8'h58, 3'd4);
        tick();
        chk("bp.drained", 32'(m_valid), 32'd0);

        // 5: short words via s_last
        beat(8'hA1, 1'b0);
        beat(8'hA2, 1'b1);
        chk_word("short2", 8'hA1, 8'hA2, 8'h00, 8'h00, 3'd2);
        beat(8'hB0, 1'b1);
        chk_word("short1", 8'hB0, 8'h00, 8'h00, 8'h00, 3'd1);
        beat(8'hC1, 1'b0);
        beat(8'hC2, 1'b0);
        beat(8'hC3, 1'b0);
        beat(8'hC4, 1'b1);
        chk_word("last4", 8'hC1, 8'hC2, 8'hC3, 8'hC4, 3'd4);
        tick();

        // 6: sclr with pending word and cnt=3 drops everything
        m_ready = 1'b0;
        beat(8'h61, 1'b0);
        beat(8'h62, 1'b0);
        beat(8'h63, 1'b0);
        beat(8'h64, 1'b0);
        beat(8'h65, 1'b0);
        beat(8'h66, 1'b0);
        beat(8'h67, 1'b0);
        chk_word("sclr.pre", 8'h61, 8'h62, 8'h63, 8'h64, 3'd4);
        sclr    = 1'b1;
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h68;
        tick();
        sclr    = 1'b0;
        s_valid = 1'b0;
        chk("sclr.m_valid", 32'(m_valid), 32'd0);
        chk("sclr.m_count", 32'(m_count), 32'd0);
        chk("sclr.d0", 32'(m_data[0]), 32'd0);
        chk("sclr.d3", 32'(m_data[3]), 32'd0);
        beat(8'h71, 1'b0);
        beat(8'h72, 1'b0);
        beat(8'h73, 1'b0);
        chk("sclr.cnt0", 32'(m_valid), 32'd0);
        beat(8'h74, 1'b0);
        chk_word("sclr.fresh", 8'h71, 8'h72, 8'h73, 8'h74, 3'd4);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
